coeff_stream_decoder: RTL and testbench
=======================================

Name: coeff_stream_decoder

Overview:
- Parametrised successor of the single-channel entropy value decoder.
- Turns (run, size, amplitude) symbols from the Huffman front end into signed coefficients with their zigzag index.
- Keeps a DC predictor per colour channel and understands EOB and ZRL markers.
- Adds a valid/ready handshake and error reporting; sits between the Huffman symbol decoder and the dequantiser / inverse-zigzag stage.

Parameters:
NUM_CHANNELS, 3, number of independent DC predictors (components)
MAX_SIZE, 11, maximum amplitude category; width of value_in
COEFF_W, 12, signed coefficient / predictor width
BLOCK_LEN, 64, coefficients per block; index width IDX_W = clog2(BLOCK_LEN)
DELTA_DECODE, 1, 1 = DC values are differences added to the channel predictor; 0 = DC passed as-is

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous, active-low reset
valid_in  input  1  symbol valid
ready_out  output  1  block can accept a symbol this cycle
value_in  input  MAX_SIZE  raw amplitude bits; only the low size_in bits are meaningful
size_in  input  clog2(MAX_SIZE+1)  amplitude category (0..MAX_SIZE)
run_in  input  4  preceding zero run (AC only)
dc_in  input  1  symbol is the DC term of a block
chan_in  input  max(1,clog2(NUM_CHANNELS))  channel of the current block
restart_in  input  1  restart marker: clear predictors and position
value_out  output  COEFF_W signed  decoded coefficient
index_out  output  IDX_W  zigzag position of value_out
chan_out  output  same as chan_in  channel of value_out
last_out  output  1  final beat of a block
valid_out  output  1  output beat valid
ready_in  input  1  downstream accepts beat
err_out  output  1  sticky protocol error

Behaviour:
- Reset (rst_in=0 at a clock edge):
  - valid_out, last_out, err_out, value_out, index_out and chan_out go to 0.
  - All predictors go to 0 and the position counter pos goes to 0.
  - ready_out=0 while rst_in=0.
- Handshake:
  - ready_out = rst_in && (!valid_out || ready_in); this is combinational.
  - A symbol is accepted when valid_in && ready_out.
  - Latency is 1 cycle: the registered output beat appears the cycle after acceptance.
  - The beat is held stable while valid_out && !ready_in.
  - valid_out drops after a handshake if no new beat is produced.
- Sign extension, ext(v,s):
  - s=0 gives 0.
  - If v[s-1]=1, the result is v masked to s bits.
  - Otherwise the result is (v mod 2^s) - (2^s - 1).
  - Bits of value_in at or above size_in are ignored.
- DC symbol (dc_in=1):
  - d = ext(value_in,size_in).
  - With DELTA_DECODE=1: out = pred[chan_in] + d, wrapped mod 2^COEFF_W, and pred[chan_in] <= out.
  - With DELTA_DECODE=0: out = d, and the predictor is untouched.
  - The beat carries index 0 and chan_in; pos <= 1.
  - If pos != 0 on entry, set err_out; the symbol is still processed.
  - run_in is ignored.
- AC with size_in != 0:
  - p = pos + run_in.
  - If p <= BLOCK_LEN-1: emit ext() at index p. When p = BLOCK_LEN-1, last_out=1 and pos <= 0; otherwise pos <= p+1.
  - If p > BLOCK_LEN-1: set err_out, emit nothing, pos <= 0.
- ZRL (size_in=0, run_in=15):
  - pos <= pos+16 and no beat is emitted.
  - If pos+16 > BLOCK_LEN-1: set err_out, pos <= 0.
- EOB (size_in=0, run_in=0):
  - Emit value 0, index BLOCK_LEN-1, last_out=1; pos <= 0.
- Any other size_in=0 AC symbol, or size_in > MAX_SIZE: set err_out, consume the symbol, no beat, pos unchanged.
- Non-emitting symbols still need ready_out=1 to be accepted. They leave the output register alone, or clear valid_out if it was just handshaken.
- chan_in >= NUM_CHANNELS: set err_out and use predictor 0.
- restart_in (sampled every cycle, no handshake):
  - Zeros all predictors and pos.
  - If coincident with an accepted symbol, the restart takes effect first: the symbol sees pred=0 and pos=0.
  - The pending output beat is unaffected.
- err_out is sticky until reset.

Decomposition:
- Package coeff_codec_pkg holds:
  - RUN_ZRL=15 and RUN_EOB=0 constants;
  - the IDX_W/BLOCK_LEN defaults;
  - function sign_extend(value, size) returning COEFF_W signed, shared with the encoder-side size computation.
- One sub-module, dc_predictor_bank:
  - NUM_CHANNELS x COEFF_W register file with synchronous clear-all (reset or restart);
  - one read port (combinational, by chan) and one write port.
- The top level holds the position counter, symbol classification, and the output register with the handshake.

Test Plan:
1. Reset then DC chan0 size=3 value=3'b010 -> beat value=-5, index=0. Then DC chan0 size=2 value=2'b11 -> value=-2. Then DC chan1 size=1 value=1 -> value=+1 (independent predictor).
2. After a DC, send AC run=2 size=4 value=4'b0110 -> index=3, value=-9. Then EOB -> value=0, index=63, last=1. Next DC accepted with err_out=0.
3. DC, then ZRL x3 (pos 49), then AC run=14 size=1 value=1 -> index=63, value=1, last=1, pos back to 0, no error.
4. DC, then ZRL x4 -> err_out=1, no beats emitted after the DC, pos=0.
5. Hold ready_in=0 for 5 cycles with valid_in streaming -> first beat stable, ready_out=0, no symbol lost. Then ready_in=1 -> beats emerge in order at 1 per cycle.
6. With chan0 predictor at 40, pulse restart_in in the same cycle as DC chan0 size=2 value=2'b10 -> value=+2 (not 42). Reset mid-block (rst_in=0 one cycle) -> all outputs 0, then the next DC gives no error.

Source files
------------

// File: rtl/coeff_codec_pkg.sv
// ---------------------------------------------------------------------------
// coeff_codec_pkg
//   Shared definitions for the coefficient stream codec.
//   - RUN_ZRL / RUN_EOB : run values that mark the zero-size marker symbols
//   - DEF_BLOCK_LEN / DEF_IDX_W : default block geometry
//   - sym_kind_e : classification of an incoming (run, size, dc) symbol
//   - sign_extend() : amplitude-category decode. The encoder side uses the
//     same function when it computes sizes, so both directions agree.
// ---------------------------------------------------------------------------
package coeff_codec_pkg;

  localparam int DEF_BLOCK_LEN = 64;
  localparam int DEF_IDX_W     = $clog2(DEF_BLOCK_LEN);

  localparam logic [3:0] RUN_ZRL = 4'd15;
  localparam logic [3:0] RUN_EOB = 4'd0;

  // Wide working width for sign_extend; callers truncate to their COEFF_W.
  localparam int SE_W = 32;

  typedef enum logic [2:0] {
    SYM_DC,
    SYM_AC,
    SYM_ZRL,
    SYM_EOB,
    SYM_BAD
  } sym_kind_e;

  // Amplitude decode: a leading 1 in the low 'size' bits means a positive
  // value taken as-is; a leading 0 means a negative value equal to the raw
  // bits minus (2^size - 1). Bits at or above 'size' are ignored.
  function automatic logic signed [SE_W-1:0] sign_extend(
    input logic [SE_W-1:0] value,
    input logic [4:0]      size
  );
    logic [SE_W-1:0] mask;
    logic [SE_W-1:0] low;
    mask = (SE_W'(1) << size) - SE_W'(1);
    low  = value & mask;
    if (size == 5'd0) begin
      return '0;
    end
    if (low[size - 5'd1]) begin
      return signed'(low);
    end
    return signed'(low - mask);
  endfunction

endpackage

// File: rtl/dc_predictor_bank.sv
// ---------------------------------------------------------------------------
// dc_predictor_bank
//   One DC predictor register per colour channel.
//   Ports:
//     clk_in, rst_in     : clock, synchronous active-low reset
//     clear_in           : synchronous clear of every predictor (restart)
//     rd_chan_in         : combinational read address
//     rd_data_out        : predictor value for rd_chan_in
//     wr_en_in           : write strobe
//     wr_chan_in         : write address
//     wr_data_in         : new predictor value
//   A write coincident with clear_in wins for its own entry, so a symbol that
//   arrives together with a restart leaves its freshly decoded value behind.
// ---------------------------------------------------------------------------
module dc_predictor_bank
  import coeff_codec_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int COEFF_W      = 12,
  parameter int CH_W         = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      clear_in,
  input  logic [CH_W-1:0]           rd_chan_in,
  output logic signed [COEFF_W-1:0] rd_data_out,
  input  logic                      wr_en_in,
  input  logic [CH_W-1:0]           wr_chan_in,
  input  logic signed [COEFF_W-1:0] wr_data_in
);

  logic signed [COEFF_W-1:0] r_pred [NUM_CHANNELS];

  // NOTE: this register file is reset entry by entry on purpose: a restart
  // must clear every predictor in one cycle, so it cannot live in a RAM.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_pred[i] <= '0;
      end
    end else begin
      if (clear_in) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          r_pred[i] <= '0;
        end
      end
      if (wr_en_in) begin
        r_pred[wr_chan_in] <= wr_data_in;
      end
    end
  end

  assign rd_data_out = r_pred[rd_chan_in];

endmodule

// File: rtl/coeff_stream_decoder.sv
// ---------------------------------------------------------------------------
// coeff_stream_decoder
//   Turns (run, size, amplitude) symbols into signed coefficients tagged with
//   their zigzag index, tracking a DC predictor per channel and handling the
//   EOB / ZRL markers. One-cycle latency, valid/ready on both sides.
//   Ports:
//     clk_in, rst_in            : clock, synchronous active-low reset
//     valid_in / ready_out      : symbol handshake
//     value_in, size_in, run_in : raw amplitude bits, category, zero run
//     dc_in, chan_in            : DC flag and channel of the current block
//     restart_in                : clear predictors and position (no handshake)
//     value_out, index_out      : decoded coefficient and zigzag position
//     chan_out, last_out        : channel and end-of-block flag of the beat
//     valid_out / ready_in      : beat handshake
//     err_out                   : sticky protocol error
// ---------------------------------------------------------------------------
module coeff_stream_decoder
  import coeff_codec_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int MAX_SIZE     = 11,
  parameter int COEFF_W      = 12,
  parameter int BLOCK_LEN    = DEF_BLOCK_LEN,
  parameter bit DELTA_DECODE = 1'b1,
  localparam int IDX_W = $clog2(BLOCK_LEN),
  localparam int SZ_W  = $clog2(MAX_SIZE + 1),
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [MAX_SIZE-1:0]       value_in,
  input  logic [SZ_W-1:0]           size_in,
  input  logic [3:0]                run_in,
  input  logic                      dc_in,
  input  logic [CH_W-1:0]           chan_in,
  input  logic                      restart_in,
  output logic signed [COEFF_W-1:0] value_out,
  output logic [IDX_W-1:0]          index_out,
  output logic [CH_W-1:0]           chan_out,
  output logic                      last_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      err_out
);

  // Position arithmetic needs headroom for pos + 16 and pos + run.
  localparam int PW = IDX_W + 5;
  localparam logic [PW-1:0]    LAST_POS = PW'(BLOCK_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

  logic                      r_valid;
  logic                      r_last;
  logic                      r_err;
  logic signed [COEFF_W-1:0] r_value;
  logic [IDX_W-1:0]          r_index;
  logic [CH_W-1:0]           r_chan;
  logic [IDX_W-1:0]          r_pos;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_chan_ok;
  logic [CH_W-1:0]           w_pred_chan;
  logic signed [COEFF_W-1:0] w_pred_rd;
  logic signed [COEFF_W-1:0] w_pred;
  logic signed [COEFF_W-1:0] w_ext;
  logic signed [COEFF_W-1:0] w_dc_val;
  logic [PW-1:0]             w_pos_eff;
  logic [PW-1:0]             w_p;
  logic [PW-1:0]             w_zrl_p;

  sym_kind_e                 w_kind;
  logic                      w_emit;
  logic signed [COEFF_W-1:0] w_beat_val;
  logic [IDX_W-1:0]          w_beat_idx;
  logic                      w_beat_last;
  logic [IDX_W-1:0]          w_next_pos;
  logic                      w_err;
  logic                      w_pred_we;

  assign w_ready   = rst_in && (!r_valid || ready_in);
  assign w_accept  = valid_in && w_ready;
  assign ready_out = w_ready;

  // A restart in the same cycle as a symbol is applied first, so the symbol
  // sees a cleared predictor and position 0.
  assign w_pos_eff   = restart_in ? '0 : PW'(r_pos);
  assign w_chan_ok   = (int'(chan_in) < NUM_CHANNELS);
  assign w_pred_chan = w_chan_ok ? chan_in : '0;
  assign w_pred      = restart_in ? '0 : w_pred_rd;

  assign w_ext    = COEFF_W'(sign_extend(SE_W'(value_in), 5'(size_in)));
  assign w_dc_val = DELTA_DECODE ? (w_pred + w_ext) : w_ext;
  assign w_p      = w_pos_eff + PW'(run_in);
  assign w_zrl_p  = w_pos_eff + PW'(16);

  always_comb begin
    w_kind = SYM_BAD;
    if (int'(size_in) > MAX_SIZE) begin
      w_kind = SYM_BAD;
    end else if (dc_in) begin
      w_kind = SYM_DC;
    end else if (size_in != '0) begin
      w_kind = SYM_AC;
    end else if (run_in == RUN_ZRL) begin
      w_kind = SYM_ZRL;
    end else if (run_in == RUN_EOB) begin
      w_kind = SYM_EOB;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_emit      = 1'b0;
    w_beat_val  = '0;
    w_beat_idx  = '0;
    w_beat_last = 1'b0;
    w_next_pos  = w_pos_eff[IDX_W-1:0];
    w_err       = !w_chan_ok;
    w_pred_we   = 1'b0;
    unique case (w_kind)
      SYM_DC: begin
        w_emit     = 1'b1;
        w_beat_val = w_dc_val;
        w_next_pos = IDX_W'(1);
        w_pred_we  = DELTA_DECODE;
        if (w_pos_eff != '0) w_err = 1'b1;
      end
      SYM_AC: begin
        if (w_p <= LAST_POS) begin
          w_emit      = 1'b1;
          w_beat_val  = w_ext;
          w_beat_idx  = w_p[IDX_W-1:0];
          w_beat_last = (w_p == LAST_POS);
          w_next_pos  = (w_p == LAST_POS) ? '0 : (w_p[IDX_W-1:0] + IDX_W'(1));
        end else begin
          w_err      = 1'b1;
          w_next_pos = '0;
        end
      end
      SYM_ZRL: begin
        if (w_zrl_p > LAST_POS) begin
          w_err      = 1'b1;
          w_next_pos = '0;
        end else begin
          w_next_pos = w_zrl_p[IDX_W-1:0];
        end
      end
      SYM_EOB: begin
        w_emit      = 1'b1;
        w_beat_idx  = LAST_IDX;
        w_beat_last = 1'b1;
        w_next_pos  = '0;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  dc_predictor_bank #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .COEFF_W      (COEFF_W),
    .CH_W         (CH_W)
  ) u_pred_bank (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (restart_in),
    .rd_chan_in  (w_pred_chan),
    .rd_data_out (w_pred_rd),
    .wr_en_in    (w_accept && w_pred_we),
    .wr_chan_in  (w_pred_chan),
    .wr_data_in  (w_dc_val)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_value <= '0;
      r_index <= '0;
      r_chan  <= '0;
      r_pos   <= '0;
    end else begin
      if (w_accept && w_emit) begin
        r_valid <= 1'b1;
        r_value <= w_beat_val;
        r_index <= w_beat_idx;
        r_chan  <= chan_in;
        r_last  <= w_beat_last;
      end else if (r_valid && ready_in) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_pos <= w_next_pos;
      end else if (restart_in) begin
        r_pos <= '0;
      end

      if (w_accept && w_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign value_out = r_value;
  assign index_out = r_index;
  assign chan_out  = r_chan;
  assign last_out  = r_last;
  assign valid_out = r_valid;
  assign err_out   = r_err;

endmodule

// File: tb/tb_coeff_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_coeff_stream_decoder
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (integer arithmetic on predictors, position and one pending beat) is
//   advanced at every rising edge and compared with the DUT half a cycle
//   later, on the falling edge.
// ---------------------------------------------------------------------------
module tb_coeff_stream_decoder;

  localparam int NCH  = 3;
  localparam int MAXS = 11;
  localparam int CW   = 12;
  localparam int BL   = 64;

  logic              clk_in;
  logic              rst_in;
  logic              valid_in;
  logic              ready_out;
  logic [MAXS-1:0]   value_in;
  logic [3:0]        size_in;
  logic [3:0]        run_in;
  logic              dc_in;
  logic [1:0]        chan_in;
  logic              restart_in;
  logic signed [CW-1:0] value_out;
  logic [5:0]        index_out;
  logic [1:0]        chan_out;
  logic              last_out;
  logic              valid_out;
  logic              ready_in;
  logic              err_out;

  coeff_stream_decoder dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .value_in   (value_in),
    .size_in    (size_in),
    .run_in     (run_in),
    .dc_in      (dc_in),
    .chan_in    (chan_in),
    .restart_in (restart_in),
    .value_out  (value_out),
    .index_out  (index_out),
    .chan_out   (chan_out),
    .last_out   (last_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .err_out    (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int m_pred [NCH];
  int m_pos;
  bit m_err;
  bit m_valid;
  bit m_last;
  int m_val;
  int m_idx;
  int m_chan;

  function automatic int wrap(input int x);
    int y;
    y = x & ((1 << CW) - 1);
    if (y >= (1 << (CW - 1))) y = y - (1 << CW);
    return y;
  endfunction

  function automatic int ext(input int v, input int s);
    int m;
    if (s == 0) return 0;
    m = v % (1 << s);
    if (((m >> (s - 1)) & 1) == 1) return m;
    return m - ((1 << s) - 1);
  endfunction

  function automatic bit m_ready();
    return rst_in && (!m_valid || ready_in);
  endfunction

  task automatic m_emit(input int v, input int idx, input int ch, input bit last);
    m_valid = 1'b1;
    m_val   = v;
    m_idx   = idx;
    m_chan  = ch;
    m_last  = last;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) m_pred[i] = 0;
    m_pos = 0; m_err = 0; m_valid = 0; m_last = 0;
    m_val = 0; m_idx = 0; m_chan = 0;
  endtask

  task automatic m_symbol();
    int ch;
    int sz;
    int run;
    int p;
    int d;
    sz  = int'(size_in);
    run = int'(run_in);
    ch  = int'(chan_in);
    if (ch >= NCH) begin
      m_err = 1;
      ch = 0;
    end
    if (sz > MAXS) begin
      m_err = 1;
    end else if (dc_in) begin
      if (m_pos != 0) m_err = 1;
      d = wrap(m_pred[ch] + ext(int'(value_in), sz));
      m_pred[ch] = d;
      m_emit(d, 0, int'(chan_in), 1'b0);
      m_pos = 1;
    end else if (sz != 0) begin
      p = m_pos + run;
      if (p <= BL - 1) begin
        m_emit(wrap(ext(int'(value_in), sz)), p, int'(chan_in), p == BL - 1);
        m_pos = (p == BL - 1) ? 0 : p + 1;
      end else begin
        m_err = 1;
        m_pos = 0;
      end
    end else if (run == 15) begin
      if (m_pos + 16 > BL - 1) begin
        m_err = 1;
        m_pos = 0;
      end else begin
        m_pos = m_pos + 16;
      end
    end else if (run == 0) begin
      m_emit(0, BL - 1, int'(chan_in), 1'b1);
      m_pos = 0;
    end else begin
      m_err = 1;
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic m_step();
    bit acc;
    if (!rst_in) begin
      m_reset();
    end else begin
      acc = valid_in && m_ready();
      if (m_valid && ready_in) m_valid = 0;
      if (restart_in) begin
        for (int i = 0; i < NCH; i++) m_pred[i] = 0;
        m_pos = 0;
      end
      if (acc) m_symbol();
    end
  endtask

  task automatic compare_model();
    check("ready_out", int'(ready_out), int'(m_ready()));
    check("valid_out", int'(valid_out), int'(m_valid));
    check("value_out", int'(value_out), m_val);
    check("index_out", int'(index_out), m_idx);
    check("chan_out",  int'(chan_out),  m_chan);
    check("last_out",  int'(last_out),  int'(m_last));
    check("err_out",   int'(err_out),   int'(m_err));
  endtask

  // Entered on a falling edge with inputs already driven; returns on the
  // next falling edge, where the effect of the rising edge is visible.
  task automatic cycle();
    #1;
    compare_model();
    m_step();
    @(negedge clk_in);
  endtask

  task automatic send(input bit dc, input int ch, input int sz, input int run, input int val);
    bit acc;
    valid_in = 1'b1;
    dc_in    = dc;
    chan_in  = 2'(ch);
    size_in  = 4'(sz);
    run_in   = 4'(run);
    value_in = MAXS'(val);
    for (int k = 0; k < 50; k++) begin
      #1;
      acc = valid_in && m_ready();
      #0;
      cycle_after_delay();
      if (acc) begin
        valid_in = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    valid_in = 1'b0;
  endtask

  // Same as cycle() for callers that have already spent the #1 settle time.
  task automatic cycle_after_delay();
    compare_model();
    m_step();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in     = 1'b0;
    valid_in   = 1'b0;
    restart_in = 1'b0;
    ready_in   = 1'b1;
    cycle();
    #1;
    check("rst_valid", int'(valid_out), 0);
    check("rst_ready", int'(ready_out), 0);
    check("rst_err",   int'(err_out),   0);
    check("rst_value", int'(value_out), 0);
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b0; valid_in = 1'b0; restart_in = 1'b0; ready_in = 1'b1;
    value_in = '0; size_in = '0; run_in = '0; dc_in = 1'b0; chan_in = '0;
    m_reset();
    @(posedge clk_in);
    @(negedge clk_in);

    // 1: DC predictors per channel
    do_reset();
    send(1, 0, 3, 0, 3'b010);
    check("t1_dc0_val", int'(value_out), -5);
    check("t1_dc0_idx", int'(index_out), 0);
    send(1, 0, 2, 0, 2'b11);
    check("t1_dc0b_val", int'(value_out), -2);
    send(1, 1, 1, 0, 1);
    check("t1_dc1_val", int'(value_out), 1);
    check("t1_dc1_chan", int'(chan_out), 1);

    // 2: AC then EOB
    do_reset();
    send(1, 0, 0, 0, 0);
    send(0, 0, 4, 2, 4'b0110);
    check("t2_ac_idx", int'(index_out), 3);
    check("t2_ac_val", int'(value_out), -9);
    send(0, 0, 0, 0, 0);
    check("t2_eob_val", int'(value_out), 0);
    check("t2_eob_idx", int'(index_out), 63);
    check("t2_eob_last", int'(last_out), 1);
    send(1, 0, 1, 0, 1);
    check("t2_dc_err", int'(err_out), 0);

    // 3: ZRL x3 then AC landing on the last position
    do_reset();
    send(1, 2, 0, 0, 0);
    repeat (3) send(0, 2, 0, 15, 0);
    send(0, 2, 1, 14, 1);
    check("t3_idx", int'(index_out), 63);
    check("t3_val", int'(value_out), 1);
    check("t3_last", int'(last_out), 1);
    send(1, 2, 0, 0, 0);
    check("t3_err", int'(err_out), 0);

    // 4: ZRL overflow
    do_reset();
    send(1, 0, 0, 0, 0);
    repeat (4) send(0, 0, 0, 15, 0);
    check("t4_err", int'(err_out), 1);
    check("t4_no_beat", int'(valid_out), 0);
    send(0, 0, 1, 0, 1);
    check("t4_pos0_idx", int'(index_out), 0);

    // 5: backpressure
    do_reset();
    send(1, 0, 3, 0, 3'b010);
    ready_in = 1'b0;
    valid_in = 1'b1; dc_in = 1'b0; chan_in = 2'd0;
    size_in = 4'd2; run_in = 4'd0; value_in = MAXS'(3);
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t5_hold_val", int'(value_out), -5);
      check("t5_hold_ready", int'(ready_out), 0);
    end
    ready_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    check("t5_b1_val", int'(value_out), 3);
    check("t5_b1_idx", int'(index_out), 1);
    send(0, 0, 3, 1, 7);
    check("t5_b2_idx", int'(index_out), 3);
    check("t5_b2_valid", int'(valid_out), 1);
    send(0, 0, 0, 0, 0);
    check("t5_b3_last", int'(last_out), 1);

    // 6: restart coincident with DC, then reset mid-block
    do_reset();
    send(1, 0, 6, 0, 40);
    check("t6_pred40", int'(value_out), 40);
    send(0, 0, 0, 0, 0);
    restart_in = 1'b1;
    send(1, 0, 2, 0, 2'b10);
    restart_in = 1'b0;
    check("t6_restart_val", int'(value_out), 2);
    check("t6_restart_err", int'(err_out), 0);
    send(1, 0, 1, 0, 1);
    check("t6_err_set", int'(err_out), 1);
    rst_in = 1'b0;
    cycle();
    check("t6_rst_val", int'(value_out), 0);
    check("t6_rst_idx", int'(index_out), 0);
    check("t6_rst_err", int'(err_out), 0);
    check("t6_rst_valid", int'(valid_out), 0);
    rst_in = 1'b1;
    send(1, 1, 1, 0, 0);
    check("t6_post_err", int'(err_out), 0);
    check("t6_post_val", int'(value_out), -1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_in     = ($urandom_range(0, 299) != 0);
      valid_in   = ($urandom_range(0, 9) < 7);
      ready_in   = ($urandom_range(0, 3) != 0);
      restart_in = ($urandom_range(0, 59) == 0);
      dc_in      = ($urandom_range(0, 5) == 0);
      chan_in    = 2'($urandom_range(0, 3));
      value_in   = MAXS'($urandom);
      case ($urandom_range(0, 9))
        0:       begin size_in = 4'd0; run_in = 4'd0;  end
        1:       begin size_in = 4'd0; run_in = 4'd15; end
        2:       begin size_in = 4'($urandom_range(0, 15)); run_in = 4'($urandom); end
        default: begin size_in = 4'($urandom_range(1, MAXS)); run_in = 4'($urandom_range(0, 5)); end
      endcase
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
